// File: rtl/motor_speed_lock.sv
// Revolution-period measurement and speed-lock detector for the spindle motor.
// Declares lock after a run of in-tolerance revolutions; drops on errors, stall or mode change.
module motor_speed_lock #(
  parameter logic [23:0] TOL         = 24'd16667,
  parameter int unsigned LOCK_REVS   = 8,
  parameter int unsigned UNLOCK_REVS = 2,
  parameter logic [23:0] TIMEOUT     = 24'd5000000,
  parameter logic [23:0] TARGET_30HZ = 24'd1666667,
  parameter logic [23:0] TARGET_15HZ = 24'd3333333
) (
  input  logic        i_clk_50m,
  input  logic        i_rst_n,
  input  logic        i_zero_sign,
  input  logic [3:0]  i_freq_mode,
  output logic        o_motor_state,
  output logic [23:0] o_period,
  output logic        o_period_valid,
  output logic        o_lock_lost,
  output logic        o_stall
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] ACQUIRE = 2'd1;
  localparam logic [1:0] LOCKED  = 2'd2;

  localparam logic [15:0] LOCK_N     = 16'(LOCK_REVS);
  localparam logic [15:0] UNLOCK_N   = 16'(UNLOCK_REVS);
  localparam logic [23:0] TIMEOUT_M1 = TIMEOUT - 24'd1;

  logic [1:0]  state_q, state_d;
  logic [3:0]  mode_q;
  logic [23:0] cnt_q, cnt_d;
  logic [15:0] good_q, good_d;
  logic [15:0] bad_q, bad_d;
  logic [23:0] period_q, period_d;
  logic        period_valid_d, lock_lost_d, stall_d;
  logic        period_valid_q, lock_lost_q, stall_q, motor_q;

  logic [23:0]        cnt_inc;
  logic [23:0]        target;
  logic signed [24:0] diff;
  logic [24:0]        abs_diff;
  logic               in_tol;
  logic               mode_chg;
  logic               timeout;
  logic [15:0]        good_inc, bad_inc;

  // Counter + 1 with saturation doubles as the measured period on a zero pulse.
  assign cnt_inc  = (cnt_q == 24'hFFFFFF) ? cnt_q : cnt_q + 24'd1;
  assign target   = (mode_q == 4'd1) ? TARGET_15HZ : TARGET_30HZ;
  assign diff     = $signed({1'b0, cnt_inc}) - $signed({1'b0, target});
  assign abs_diff = diff[24] ? 25'(-diff) : 25'(diff);
  assign in_tol   = abs_diff <= {1'b0, TOL};
  // Only a change of the decoded speed counts; codes 0 and 2..15 are equivalent.
  assign mode_chg = (i_freq_mode == 4'd1) != (mode_q == 4'd1);
  assign timeout  = (cnt_q == TIMEOUT_M1) && !i_zero_sign;
  assign good_inc = good_q + 16'd1;
  assign bad_inc  = bad_q + 16'd1;

  always_comb begin
    state_d        = state_q;
    good_d         = good_q;
    bad_d          = bad_q;
    cnt_d          = i_zero_sign ? 24'd0 : cnt_inc;
    period_d       = period_q;
    period_valid_d = 1'b0;
    lock_lost_d    = 1'b0;
    stall_d        = i_zero_sign ? 1'b0 : stall_q;

    // A period captured outside IDLE is always reported, even when not evaluated.
    if (i_zero_sign && (state_q != IDLE)) begin
      period_d       = cnt_inc;
      period_valid_d = 1'b1;
    end

    if (mode_chg && (state_q != IDLE)) begin
      state_d     = ACQUIRE;
      good_d      = 16'd0;
      bad_d       = 16'd0;
      lock_lost_d = (state_q == LOCKED);
    end else if (i_zero_sign) begin
      case (state_q)
        IDLE: begin
          state_d = ACQUIRE;
          good_d  = 16'd0;
          bad_d   = 16'd0;
        end
        ACQUIRE: begin
          if (in_tol) begin
            good_d = good_inc;
            if (good_inc >= LOCK_N) begin
              state_d = LOCKED;
              bad_d   = 16'd0;
            end
          end else begin
            good_d = 16'd0;
          end
        end
        LOCKED: begin
          if (in_tol) begin
            bad_d = 16'd0;
          end else begin
            bad_d = bad_inc;
            if (bad_inc >= UNLOCK_N) begin
              state_d     = ACQUIRE;
              good_d      = 16'd0;
              lock_lost_d = 1'b1;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end else if (timeout) begin
      state_d     = IDLE;
      stall_d     = 1'b1;
      lock_lost_d = (state_q == LOCKED);
    end
  end

  always_ff @(posedge i_clk_50m or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q        <= IDLE;
      mode_q         <= 4'd0;
      cnt_q          <= 24'd0;
      good_q         <= 16'd0;
      bad_q          <= 16'd0;
      period_q       <= 24'd0;
      period_valid_q <= 1'b0;
      lock_lost_q    <= 1'b0;
      stall_q        <= 1'b0;
      motor_q        <= 1'b0;
    end else begin
      state_q        <= state_d;
      mode_q         <= i_freq_mode;
      cnt_q          <= cnt_d;
      good_q         <= good_d;
      bad_q          <= bad_d;
      period_q       <= period_d;
      period_valid_q <= period_valid_d;
      lock_lost_q    <= lock_lost_d;
      stall_q        <= stall_d;
      motor_q        <= (state_d == LOCKED);
    end
  end

  assign o_motor_state  = motor_q;
  assign o_period       = period_q;
  assign o_period_valid = period_valid_q;
  assign o_lock_lost    = lock_lost_q;
  assign o_stall        = stall_q;

endmodule

// File: tb/tb_motor_speed_lock.sv
// Directed bench for motor_speed_lock with scaled-down targets and timeout.
module tb_motor_speed_lock;

  localparam int unsigned TMO = 1000;

  logic        clk;
  logic        rst_n;
  logic        zero_sign;
  logic [3:0]  freq_mode;
  logic        motor_state;
  logic [23:0] period;
  logic        period_valid;
  logic        lock_lost;
  logic        stall;

  int n_checks = 0;
  int n_fail   = 0;

  motor_speed_lock #(
    .TOL         (24'd4),
    .LOCK_REVS   (8),
    .UNLOCK_REVS (2),
    .TIMEOUT     (24'(TMO)),
    .TARGET_30HZ (24'd200),
    .TARGET_15HZ (24'd400)
  ) dut (
    .i_clk_50m      (clk),
    .i_rst_n        (rst_n),
    .i_zero_sign    (zero_sign),
    .i_freq_mode    (freq_mode),
    .o_motor_state  (motor_state),
    .o_period       (period),
    .o_period_valid (period_valid),
    .o_lock_lost    (lock_lost),
    .o_stall        (stall)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Waits n negedges, drives a one-cycle zero pulse, then checks the registered response.
  task automatic pulse_after(input string tag, input int n, input logic exp_valid,
                             input logic [23:0] exp_period, input logic exp_motor,
                             input logic exp_lost);
    repeat (n) @(negedge clk);
    zero_sign = 1'b1;
    @(negedge clk);
    zero_sign = 1'b0;
    check($sformatf("%s.valid", tag), 32'(period_valid), 32'(exp_valid));
    check($sformatf("%s.period", tag), 32'(period), 32'(exp_period));
    check($sformatf("%s.motor", tag), 32'(motor_state), 32'(exp_motor));
    check($sformatf("%s.lost", tag), 32'(lock_lost), 32'(exp_lost));
  endtask

  initial begin
    rst_n     = 1'b0;
    zero_sign = 1'b0;
    freq_mode = 4'd0;
    #5;
    check("rst.motor", 32'(motor_state), 32'd0);
    check("rst.period", 32'(period), 32'd0);
    check("rst.valid", 32'(period_valid), 32'd0);
    check("rst.lost", 32'(lock_lost), 32'd0);
    check("rst.stall", 32'(stall), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Acquire at 30 Hz: first pulse from IDLE is silent, then 8 good revolutions lock.
    pulse_after("first", 20, 1'b0, 24'd0, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++)
      pulse_after("acq30", 199, 1'b1, 24'd200, (i == 7), 1'b0);

    // One bad then good keeps lock; two consecutive bad drop it.
    pulse_after("bad1", 214, 1'b1, 24'd215, 1'b1, 1'b0);
    pulse_after("good", 199, 1'b1, 24'd200, 1'b1, 1'b0);
    pulse_after("bad2", 214, 1'b1, 24'd215, 1'b1, 1'b0);
    pulse_after("bad3", 214, 1'b1, 24'd215, 1'b0, 1'b1);
    @(negedge clk);
    check("lost.strobe_end", 32'(lock_lost), 32'd0);

    // Tolerance boundaries: 205 is out and clears progress, 204 and 196 are in.
    pulse_after("reacq", 198, 1'b1, 24'd200, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++)
      pulse_after("reacq", 199, 1'b1, 24'd200, 1'b0, 1'b0);
    pulse_after("out205", 204, 1'b1, 24'd205, 1'b0, 1'b0);
    pulse_after("in204", 203, 1'b1, 24'd204, 1'b0, 1'b0);
    pulse_after("in196", 195, 1'b1, 24'd196, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++)
      pulse_after("reacq2", 199, 1'b1, 24'd200, 1'b0, 1'b0);
    pulse_after("relock", 199, 1'b1, 24'd200, 1'b1, 1'b0);

    // Mode change while locked drops lock, then relock at 15 Hz.
    freq_mode = 4'd1;
    @(negedge clk);
    check("mode.lost", 32'(lock_lost), 32'd1);
    check("mode.motor", 32'(motor_state), 32'd0);
    @(negedge clk);
    check("mode.lost_end", 32'(lock_lost), 32'd0);
    pulse_after("acq15", 397, 1'b1, 24'd400, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++)
      pulse_after("acq15", 399, 1'b1, 24'd400, 1'b0, 1'b0);
    pulse_after("lock15", 399, 1'b1, 24'd400, 1'b1, 1'b0);

    // Stall: pulses stop while locked.
    repeat (TMO - 1) @(negedge clk);
    check("prestall.stall", 32'(stall), 32'd0);
    check("prestall.motor", 32'(motor_state), 32'd1);
    @(negedge clk);
    check("stall.stall", 32'(stall), 32'd1);
    check("stall.motor", 32'(motor_state), 32'd0);
    check("stall.lost", 32'(lock_lost), 32'd1);
    @(negedge clk);
    check("stall.lost_end", 32'(lock_lost), 32'd0);
    check("stall.level", 32'(stall), 32'd1);
    pulse_after("unstall", 10, 1'b0, 24'd400, 1'b0, 1'b0);
    check("unstall.stall", 32'(stall), 32'd0);
    for (int i = 0; i < 8; i++)
      pulse_after("lock15b", 399, 1'b1, 24'd400, (i == 7), 1'b0);

    // Asynchronous reset while locked, then a lone pulse stays silent.
    repeat (50) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("arst.motor", 32'(motor_state), 32'd0);
    check("arst.period", 32'(period), 32'd0);
    check("arst.stall", 32'(stall), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    pulse_after("postrst", 50, 1'b0, 24'd0, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
